// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_GENCALL_ADDR = 7'h00;
    localparam logic       I2C_RW_WRITE     = 1'b0;

    // Open-drain enable needed to put the given acknowledge bit on SDA.
    function automatic logic oe_for(input logic ack_bit);
        return ack_bit == I2C_ACK;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus glitch filter for one I2C line; emits the filtered level and edge strobes.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk_in,
    input  logic rstn_in,
    input  logic line_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= line_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // The counter tracks how long the synchronized line has disagreed with the filtered level.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            level_out <= 1'b1;
            cnt_q     <= '0;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
        end else begin
            rise_out <= 1'b0;
            fall_out <= 1'b0;
            if (synced == level_out) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_out <= synced;
                cnt_q     <= '0;
                rise_out  <= synced;
                fall_out  <= ~synced;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target receiver with address match, ACK generation and a one-entry byte buffer.
// Optional general-call support is enabled with the macro I2C_GENCALL_EN.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe_out,
    input  logic       enable_in,
    input  logic [6:0] own_addr_in,
    output logic [7:0] data_out,
    output logic       data_valid_out,
    input  logic       data_ready_in,
    output logic       addr_hit_out,
    output logic       stop_out,
    output logic       busy_out,
`ifdef I2C_GENCALL_EN
    output logic       gencall_out,
`endif
    output logic       overrun_out
);

`ifdef I2C_GENCALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif

    logic       scl_lvl, scl_rise, scl_fall;
    logic       sda_lvl, sda_rise, sda_fall;
    logic       start_evt, stop_evt;
    logic       last_bit, is_own, is_gc, addr_ok;
    logic [7:0] full_byte;
    logic [6:0] shreg;
    logic [2:0] bitcnt;
    i2c_state_t state;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_in    (clk_in),
        .rstn_in   (rstn_in),
        .line_in   (scl_in),
        .level_out (scl_lvl),
        .rise_out  (scl_rise),
        .fall_out  (scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_in    (clk_in),
        .rstn_in   (rstn_in),
        .line_in   (sda_in),
        .level_out (sda_lvl),
        .rise_out  (sda_rise),
        .fall_out  (sda_fall)
    );

    // Both lines share the same delay, so SDA edges can be judged against the filtered SCL level.
    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;
    assign full_byte = {shreg, sda_lvl};
    assign last_bit  = scl_rise && (bitcnt == 3'd7);
    assign is_own    = (full_byte[7:1] == own_addr_in);
    assign is_gc     = GC_EN && (full_byte[7:1] == I2C_GENCALL_ADDR);
    assign addr_ok   = enable_in && (full_byte[0] == I2C_RW_WRITE) && (is_own || is_gc);

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state          <= ST_IDLE;
            shreg          <= '0;
            bitcnt         <= '0;
            sda_oe_out     <= 1'b0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            addr_hit_out   <= 1'b0;
            stop_out       <= 1'b0;
            busy_out       <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            addr_hit_out <= 1'b0;
            stop_out     <= 1'b0;
            if (data_valid_out && data_ready_in) begin
                data_valid_out <= 1'b0;
            end

            if (!enable_in) begin
                state       <= ST_IDLE;
                bitcnt      <= '0;
                sda_oe_out  <= 1'b0;
                busy_out    <= 1'b0;
                overrun_out <= 1'b0;
            end else if (stop_evt) begin
                state      <= ST_IDLE;
                sda_oe_out <= 1'b0;
                stop_out   <= busy_out;
                busy_out   <= 1'b0;
            end else if (start_evt) begin
                state      <= ST_ADDR;
                bitcnt     <= '0;
                sda_oe_out <= 1'b0;
                busy_out   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg  <= full_byte[6:0];
                            bitcnt <= bitcnt + 3'd1;
                            if (last_bit) begin
                                if (addr_ok) begin
                                    addr_hit_out <= 1'b1;
                                    busy_out     <= 1'b1;
                                    state        <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    // First SCL fall starts driving the ACK, the next one ends the ACK clock.
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_out) begin
                                sda_oe_out <= oe_for(I2C_ACK);
                            end else begin
                                sda_oe_out <= oe_for(I2C_NACK);
                                bitcnt     <= '0;
                                state      <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise) begin
                            shreg  <= full_byte[6:0];
                            bitcnt <= bitcnt + 3'd1;
                            if (last_bit) begin
                                if (!data_valid_out || data_ready_in) begin
                                    data_out       <= full_byte;
                                    data_valid_out <= 1'b1;
                                    state          <= ST_DATA_ACK;
                                end else begin
                                    overrun_out <= 1'b1;
                                    state       <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe_out <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef I2C_GENCALL_EN
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            gencall_out <= 1'b0;
        end else if (!enable_in || start_evt || stop_evt) begin
            gencall_out <= 1'b0;
        end else if ((state == ST_ADDR) && last_bit && addr_ok) begin
            gencall_out <= is_gc;
        end
    end
`endif

endmodule
